// File: rtl/laser_tx_arbiter.sv
// Frame-level arbiter sharing the laser TX stream between distance, status and aux framers.
// Optional stall watchdog (ABORT/FLUSH states) is built when LASER_TX_ARB_WDOG_EN is defined.
module laser_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter logic [31:0] ABORT_WORD  = 32'hdeadbeef
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    input  logic [31:0] s0_data,
    input  logic        s0_last,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [31:0] s1_data,
    input  logic        s1_last,
    output logic        s1_ready,
    input  logic        s2_valid,
    input  logic [31:0] s2_data,
    input  logic        s2_last,
    output logic        s2_ready,
    input  logic        laser_fifo_in_ready,
    output logic        laser_fifo_in_valid,
    output logic [31:0] laser_fifo_in_data,
    output logic [2:0]  grant,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] abort_cnt
);

`ifdef LASER_TX_ARB_WDOG_EN
    typedef enum logic [1:0] {IDLE, PASS, ABORT, FLUSH} state_t;
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYC - 1);
`else
    typedef enum logic [0:0] {IDLE, PASS} state_t;
`endif

    state_t      state, state_nxt;
    logic [2:0]  grant_nxt;
    logic [2:0]  winner;
    logic [2:0]  src_ready;
    logic        rr, rr_nxt;          // 0: source 1 preferred, 1: source 2 preferred
    logic        frame_inc;
    logic        sel_valid, sel_last;
    logic [31:0] sel_data;
`ifdef LASER_TX_ARB_WDOG_EN
    logic        abort_inc;
    logic [15:0] stall_cnt;
`endif

    // Granted source's handshake, steered by the one-hot grant register.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        if (grant[0]) begin
            sel_valid = s0_valid;
            sel_last  = s0_last;
            sel_data  = s0_data;
        end else if (grant[1]) begin
            sel_valid = s1_valid;
            sel_last  = s1_last;
            sel_data  = s1_data;
        end else if (grant[2]) begin
            sel_valid = s2_valid;
            sel_last  = s2_last;
            sel_data  = s2_data;
        end
    end

    // Source 0 has absolute priority; 1 vs 2 alternate via rr.
    always_comb begin
        winner = 3'b000;
        if (s0_valid)
            winner = 3'b001;
        else if (s1_valid && (!rr || !s2_valid))
            winner = 3'b010;
        else if (s2_valid)
            winner = 3'b100;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt           = state;
        grant_nxt           = grant;
        rr_nxt              = rr;
        frame_inc           = 1'b0;
        src_ready           = 3'b000;
        laser_fifo_in_valid = 1'b0;
        laser_fifo_in_data  = '0;
`ifdef LASER_TX_ARB_WDOG_EN
        abort_inc           = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|winner) begin
                    grant_nxt = winner;
                    state_nxt = PASS;
                    if (winner[1])
                        rr_nxt = 1'b1;
                    else if (winner[2])
                        rr_nxt = 1'b0;
                end
            end
            PASS: begin
                src_ready           = grant & {3{laser_fifo_in_ready}};
                laser_fifo_in_valid = sel_valid;
                laser_fifo_in_data  = sel_valid ? sel_data : '0;
                if (sel_valid && laser_fifo_in_ready && sel_last) begin
                    frame_inc = 1'b1;
                    grant_nxt = 3'b000;
                    state_nxt = IDLE;
                end
`ifdef LASER_TX_ARB_WDOG_EN
                else if (!sel_valid && stall_cnt == STALL_LIMIT) begin
                    state_nxt = ABORT;
                end
`endif
            end
`ifdef LASER_TX_ARB_WDOG_EN
            ABORT: begin
                laser_fifo_in_valid = 1'b1;
                laser_fifo_in_data  = ABORT_WORD;
                if (laser_fifo_in_ready) begin
                    abort_inc = 1'b1;
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Drain the rest of the aborted frame without forwarding it.
                src_ready = grant;
                if ((sel_valid && sel_last) || (!sel_valid && stall_cnt == STALL_LIMIT)) begin
                    grant_nxt = 3'b000;
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                grant_nxt = 3'b000;
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= 3'b000;
            rr        <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            rr    <= rr_nxt;
            if (frame_inc)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef LASER_TX_ARB_WDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            abort_cnt <= '0;
        end else begin
            if (state_nxt != state)
                stall_cnt <= '0;
            else if (state == PASS || state == FLUSH)
                stall_cnt <= sel_valid ? 16'd0 : stall_cnt + 16'd1;
            if (abort_inc && abort_cnt != 16'hffff)
                abort_cnt <= abort_cnt + 16'd1;
        end
    end
`else
    assign abort_cnt = '0;
`endif

    assign s0_ready = src_ready[0];
    assign s1_ready = src_ready[1];
    assign s2_ready = src_ready[2];
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_laser_tx_arbiter.sv
// Scoreboard bench for laser_tx_arbiter: expected words are queued with their source,
// then popped and compared as each downstream transfer is observed.
module tb_laser_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid [3];
    logic [31:0] s_data  [3];
    logic        s_last  [3];
    logic        s_ready [3];
    logic        laser_ready = 1'b1;
    logic        laser_valid;
    logic [31:0] laser_data;
    logic [2:0]  grant;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] abort_cnt;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  grant;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   bp_run;

    always #5 clk = ~clk;

    laser_tx_arbiter #(.TIMEOUT_CYC(8), .ABORT_WORD(32'hdeadbeef)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s0_valid            (s_valid[0]),
        .s0_data             (s_data[0]),
        .s0_last             (s_last[0]),
        .s0_ready            (s_ready[0]),
        .s1_valid            (s_valid[1]),
        .s1_data             (s_data[1]),
        .s1_last             (s_last[1]),
        .s1_ready            (s_ready[1]),
        .s2_valid            (s_valid[2]),
        .s2_data             (s_data[2]),
        .s2_last             (s_last[2]),
        .s2_ready            (s_ready[2]),
        .laser_fifo_in_ready (laser_ready),
        .laser_fifo_in_valid (laser_valid),
        .laser_fifo_in_data  (laser_data),
        .grant               (grant),
        .busy                (busy),
        .frame_cnt           (frame_cnt),
        .abort_cnt           (abort_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int src, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++)
            sb.push_back('{data: base + 32'(i), grant: 3'(1 << src)});
    endtask

    // Drives n words from one source, holding each until accepted; reports wait before word 0.
    task automatic send_words(input int src, input int n, input logic [31:0] base,
                              input bit with_last, output int first_wait);
        int w;
        first_wait = 0;
        for (int i = 0; i < n; i++) begin
            s_valid[src] = 1'b1;
            s_data[src]  = base + 32'(i);
            s_last[src]  = with_last && (i == n - 1);
            w = 0;
            forever begin
                @(negedge clk);
                if (s_ready[src]) break;
                w++;
                if (w > 3000) begin
                    check("src_ready_timeout", 32'(w), 0);
                    break;
                end
            end
            if (i == 0) first_wait = w;
            @(posedge clk); #1;
        end
        s_valid[src] = 1'b0;
        s_last[src]  = 1'b0;
        s_data[src]  = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(laser_valid), 0);
        check({tag, "_data"},  laser_data, 0);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_ready"}, 32'({s_ready[2], s_ready[1], s_ready[0]}), 0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
        check({tag, "_abort_cnt"}, 32'(abort_cnt), 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            s_valid[i] = 1'b0;
            s_data[i]  = '0;
            s_last[i]  = 1'b0;
        end
        laser_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
    endtask

    // Downstream monitor: every accepted word must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (laser_valid && laser_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", laser_data, 32'hffff_ffff);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", laser_data, e.data);
                    check("out_grant", 32'(grant), 32'(e.grant));
                end
            end
            if (!laser_valid)
                check("idle_data_zero", laser_data, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fw, fw0, fw1, fw2;
        logic [15:0] fc, ac;

        // Simultaneous requests: 0 beats 1 and 2, rr starts preferring 1.
        do_reset();
        push_frame(0, 2, 32'h0000_0100);
        push_frame(1, 2, 32'h0000_0200);
        push_frame(2, 2, 32'h0000_0300);
        fork
            send_words(0, 2, 32'h0000_0100, 1'b1, fw0);
            send_words(1, 2, 32'h0000_0200, 1'b1, fw1);
            send_words(2, 2, 32'h0000_0300, 1'b1, fw2);
        join
        push_frame(1, 2, 32'h0000_0400);
        push_frame(2, 2, 32'h0000_0500);
        fork
            send_words(1, 2, 32'h0000_0400, 1'b1, fw1);
            send_words(2, 2, 32'h0000_0500, 1'b1, fw2);
        join
        check("simul_sb_empty", 32'(sb.size()), 0);
        check("simul_frame_cnt", 32'(frame_cnt), 5);

        // Basic 5-word frame, then back-to-back frames with exactly one bubble.
        do_reset();
        push_frame(1, 5, 32'h0000_a000);
        send_words(1, 5, 32'h0000_a000, 1'b1, fw);
        check("basic_first_latency", 32'(fw), 1);
        push_frame(2, 3, 32'h0000_b000);
        fork
            send_words(2, 3, 32'h0000_b000, 1'b1, fw);
            begin
                @(negedge clk);
                check("bubble_busy", 32'(busy), 0);
                check("bubble_grant", 32'(grant), 0);
                check("bubble_frame_cnt", 32'(frame_cnt), 1);
            end
        join
        check("b2b_first_latency", 32'(fw), 1);
        push_frame(0, 1, 32'h0000_c0de);
        send_words(0, 1, 32'h0000_c0de, 1'b1, fw);
        check("single_word_latency", 32'(fw), 1);
        @(negedge clk);
        check("single_word_idle", 32'(busy), 0);
        check("basic_frame_cnt", 32'(frame_cnt), 3);
        @(posedge clk); #1;

        // Downstream ready toggling every cycle during an 811-word source-0 frame.
        fc = frame_cnt;
        ac = abort_cnt;
        push_frame(0, 811, 32'h8000_0000);
        bp_run = 1'b1;
        fork
            begin
                send_words(0, 811, 32'h8000_0000, 1'b1, fw);
                bp_run = 1'b0;
            end
            while (bp_run) begin
                @(posedge clk); #1;
                laser_ready = ~laser_ready;
            end
        join
        laser_ready = 1'b1;
        check("bp_sb_empty", 32'(sb.size()), 0);
        check("bp_frame_cnt", 32'(frame_cnt), 32'(fc + 16'd1));
        check("bp_abort_cnt", 32'(abort_cnt), 32'(ac));

        // Long backpressure (well past the stall timeout) must not abort.
        fc = frame_cnt;
        push_frame(1, 3, 32'h0000_d100);
        laser_ready = 1'b0;
        fork
            send_words(1, 3, 32'h0000_d100, 1'b1, fw);
            begin
                repeat (20) @(posedge clk);
                #1 laser_ready = 1'b1;
            end
        join
        check("longbp_sb_empty", 32'(sb.size()), 0);
        check("longbp_frame_cnt", 32'(frame_cnt), 32'(fc + 16'd1));
        check("longbp_abort_cnt", 32'(abort_cnt), 32'(ac));

        // Reset during word 400 of a source-0 frame; rr currently prefers source 2.
        push_frame(0, 399, 32'h4000_0000);
        send_words(0, 399, 32'h4000_0000, 1'b0, fw);
        s_valid[0] = 1'b1;
        s_data[0]  = 32'h4000_0000 + 32'd399;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        s_valid[0] = 1'b0;
        s_data[0]  = '0;
        @(negedge clk);
        check_idle_outputs("midrst");
        check("midrst_sb_empty", 32'(sb.size()), 0);
        @(posedge clk); #1;
        push_frame(1, 2, 32'h0000_e100);
        push_frame(2, 2, 32'h0000_e200);
        fork
            send_words(1, 2, 32'h0000_e100, 1'b1, fw1);
            send_words(2, 2, 32'h0000_e200, 1'b1, fw2);
        join
        check("midrst_frame_cnt", 32'(frame_cnt), 2);

`ifdef LASER_TX_ARB_WDOG_EN
        // Source 2 stalls for 8 cycles mid-frame: one abort word, rest of frame flushed.
        fc = frame_cnt;
        ac = abort_cnt;
        push_frame(2, 3, 32'h0000_f000);
        sb.push_back('{data: 32'hdeadbeef, grant: 3'b100});
        send_words(2, 3, 32'h0000_f000, 1'b0, fw);
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("wdog_abort_valid", 32'(laser_valid), 1);
        check("wdog_abort_ready", 32'({s_ready[2], s_ready[1], s_ready[0]}), 0);
        @(posedge clk); #1;
        send_words(2, 4, 32'h0000_f100, 1'b1, fw);
        @(negedge clk);
        check("wdog_idle_busy", 32'(busy), 0);
        check("wdog_abort_cnt", 32'(abort_cnt), 32'(ac + 16'd1));
        check("wdog_frame_cnt", 32'(frame_cnt), 32'(fc));
        check("wdog_sb_empty", 32'(sb.size()), 0);
`else
        // Watchdog compiled out: a 5000-cycle stall just waits for the source.
        fc = frame_cnt;
        push_frame(1, 5, 32'h0000_9000);
        send_words(1, 2, 32'h0000_9000, 1'b0, fw);
        repeat (5000) @(posedge clk);
        #1;
        @(negedge clk);
        check("nowdog_busy", 32'(busy), 1);
        check("nowdog_grant", 32'(grant), 32'b010);
        check("nowdog_abort_cnt", 32'(abort_cnt), 0);
        @(posedge clk); #1;
        send_words(1, 3, 32'h0000_9002, 1'b1, fw);
        @(negedge clk);
        check("nowdog_frame_cnt", 32'(frame_cnt), 32'(fc + 16'd1));
        check("nowdog_abort_cnt_end", 32'(abort_cnt), 0);
        check("nowdog_sb_empty", 32'(sb.size()), 0);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/laser_tx_arbiter.md
# laser_tx_arbiter

Frame-level arbiter that shares the single laser TX stream (`laser_fifo_in_*`) between three frame sources: the distance-data framer, the FPGA-status framer and an auxiliary/command-response framer. It grants one source per complete frame and never interleaves words from different frames. An optional watchdog terminates a frame whose source stalls mid-frame. It sits between the framers and the NIOS-side laser FIFO.

## Interface
- `TIMEOUT_CYC`, default 1000: number of consecutive stalled cycles in a granted frame that triggers an abort (watchdog builds only). Legal range is 2..65535.
- `ABORT_WORD`, default 32'hdeadbeef: word emitted downstream to terminate an aborted frame.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `s0_valid`, `s1_valid`, `s2_valid`  in  1 each  source word valid. Source 0 is distance data, source 1 is status, source 2 is auxiliary.
- `s0_data`, `s1_data`, `s2_data`  in  32 each  source word.
- `s0_last`, `s1_last`, `s2_last`  in  1 each  marks the final word of a frame.
- `s0_ready`, `s1_ready`, `s2_ready`  out  1 each  source word accepted when valid & ready.
- `laser_fifo_in_ready`  in  1  downstream ready.
- `laser_fifo_in_valid`  out  1  downstream valid.
- `laser_fifo_in_data`  out  32  downstream word.
- `grant`  out  3  one-hot granted source; 0 when no source is granted.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_cnt`  out  16  completed frames; wraps at 0xFFFF.
- `abort_cnt`  out  16  aborted frames; saturates at 0xFFFF.

## Operation
- States: IDLE, PASS, ABORT, FLUSH. ABORT and FLUSH exist only in watchdog builds.
- **IDLE**
  - Source ready outputs, `laser_fifo_in_valid` and `grant` are all 0.
  - If any `sX_valid` is high, select a winner, register it into `grant` and go to PASS.
- **Winner selection**
  - Source 0 always wins when its valid is high.
  - Otherwise sources 1 and 2 are arbitrated by a round-robin bit `rr`. After reset, `rr` prefers source 1.
  - Serving source 1 sets `rr` to prefer source 2. Serving source 2 sets `rr` to prefer source 1.
  - Serving source 0 leaves `rr` unchanged.
- **PASS** (combinational pass-through for the granted source X)
  - `laser_fifo_in_valid` = `sX_valid`.
  - `laser_fifo_in_data` = `sX_data`.
  - `sX_ready` = `laser_fifo_in_ready`.
  - Non-granted sources see ready = 0.
  - A word with `sX_last` high transferring (valid & ready) increments `frame_cnt`, clears `grant` and returns to IDLE.
- **Watchdog**
  - A 16-bit stall counter runs in PASS. It clears on any cycle with `sX_valid` high and increments otherwise.
  - When the counter reaches `TIMEOUT_CYC`-1 while `sX_valid` is still low, the block goes to ABORT.
  - The counter also clears on every state entry.
- **ABORT**
  - All source ready outputs are 0.
  - `laser_fifo_in_valid` = 1 and `laser_fifo_in_data` = `ABORT_WORD`.
  - On `laser_fifo_in_ready`, increment `abort_cnt` (saturating) and go to FLUSH.
- **FLUSH**
  - `sX_ready` = 1 and `laser_fifo_in_valid` = 0, so the granted source's words are discarded.
  - Accepting a word with last high goes to IDLE, clears `grant` and leaves `frame_cnt` unchanged.
  - A further `TIMEOUT_CYC` stall cycles in FLUSH also go to IDLE.
- While `laser_fifo_in_valid` is high it holds, and data stays stable, until accepted. This follows from source compliance in PASS and is guaranteed by the block in ABORT.
- `laser_fifo_in_data` is 0 whenever `laser_fifo_in_valid` is 0.

## Timing
- **Reset values:** state IDLE; all ready outputs 0; `laser_fifo_in_valid` 0; `laser_fifo_in_data` 0; `grant` 0; `busy` 0; `frame_cnt` 0; `abort_cnt` 0; `rr` prefers source 1; stall counter 0.
- **Reset mid-frame:** the frame is truncated downstream and no `ABORT_WORD` is emitted. Sources must restart their own framing.
- **Arbitration latency:** with `sX_valid` high in IDLE at cycle N, `grant` is valid from cycle N+1, and the first word can transfer in cycle N+1.
- **Back-to-back frames:** last transfer at cycle T, IDLE at T+1, next first word at T+2 at the earliest. There is exactly one bubble cycle.
- **Combinational paths:** `laser_fifo_in_ready` to `sX_ready`, and `sX_valid`/`sX_data` to the downstream outputs, in PASS only. There are no registered data stages.
- **Single-word frame:** valid & last in the first PASS cycle with ready high returns to IDLE in one cycle.
- **Simultaneous requests in IDLE:** source 0 beats 1 and 2; 1 versus 2 is resolved by `rr`.
- **Requests during PASS:** they are not sampled. They are arbitrated only in IDLE.
- **Watchdog timing:** the stall counter counts only `sX_valid` = 0 cycles. Downstream backpressure (valid high, ready low) never causes an abort.

## Configuration
- Macro: `LASER_TX_ARB_WDOG_EN`.
- **Defined:** the stall counter and the ABORT and FLUSH states are built, and behave as described above.
- **Undefined:**
  - The stall counter and ABORT/FLUSH are omitted.
  - PASS waits indefinitely for the granted source.
  - `abort_cnt` is tied to 0 and `TIMEOUT_CYC`/`ABORT_WORD` are unused.

## Test plan
- **Basic frame:** source 1 sends 5 words with last on the 5th, ready always high. Required: 5 words out in order, `grant`=3'b010 during PASS, `frame_cnt`=1, then IDLE with one bubble.
- **Simultaneous requests:** sources 0, 1 and 2 all request in the same IDLE cycle, each sending a 2-word frame. Required output order: 0, 1, 2. Then with only 1 and 2 requesting again, required order: 1, 2.
- **Backpressure:** `laser_fifo_in_ready` toggles every cycle during an 811-word source-0 frame. Required: all 811 words delivered with no loss or duplication, no abort, `frame_cnt` +1.
- **Watchdog abort:** `TIMEOUT_CYC`=8; source 2 sends 3 words, then drops valid for 8 cycles. Required: 32'hdeadbeef emitted once, `abort_cnt`=1, `frame_cnt` unchanged. The next 4 source-2 words up to last are consumed with downstream valid low.
- **Reset mid-frame:** assert `rst` for 1 cycle during word 400 of a source-0 frame. Required on the next cycle: all outputs 0, `grant`=0, counters 0. A new source-1 frame is then granted normally.
- **Watchdog compiled out:** without the macro, a source stalls for 5000 cycles. Required: no abort, `abort_cnt`=0, and the frame completes when the source resumes.
